// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register-file write-port controller.
//   DATA_W   : register data width
//   ADDR_W   : register address width
//   NUM_REGS : number of registers (2**ADDR_W)
//   state_t  : controller state (init sweep / run)
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int DATA_W   = 4;
  localparam int ADDR_W   = 2;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant unit. Holds only the priority flop; the data
// path that follows the grant lives in the instantiating module.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_en       : arbitration enabled (requests ignored when low)
//   i_req[1:0] : raw requests
//   i_mask[1:0]: per-requester mask (masked requests are not eligible)
//   o_valid    : some requester is granted this cycle
//   o_idx      : index of the granted requester (valid when o_valid)
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  input  logic [1:0] i_mask,
  output logic       o_valid,
  output logic       o_idx
);

  logic       r_prio;   // index of the requester that wins a tie
  logic [1:0] w_elig;
  logic [1:0] w_grant;

  assign w_elig = i_req & ~i_mask & {2{i_en}};

  always_comb begin
    w_grant = w_elig;
    if (w_elig == 2'b11) begin
      w_grant = r_prio ? 2'b10 : 2'b01;
    end
  end

  assign o_valid = |w_grant;
  assign o_idx   = w_grant[1];

  // Priority passes to the other requester after every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (o_valid) begin
      r_prio <= ~o_idx;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
// Owns the register file's single write port. After reset it writes
// INIT_VALUE into every register (the register file has no reset), then
// shares the port between two requesters with round-robin arbitration and
// a req/ack handshake. All outputs are registered.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req0/addr0/data0    : requester 0 (ALU writeback)
//   req1/addr1/data1    : requester 1 (load/debug path)
//   ack0, ack1          : one-cycle pulse in the cycle the write is presented
//   rf_write_addr/data/enable : register file write port
//   init_done           : init sweep finished (sticky until reset)
//   last_grant          : most recently granted requester
//   write_count         : arbitrated writes, wraps at 256
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int                 DATA_W     = regfile_pkg::DATA_W,
  parameter int                 ADDR_W     = regfile_pkg::ADDR_W,
  parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              ack0,
  output logic              ack1,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_enable,
  output logic              init_done,
  output logic              last_grant,
  output logic [7:0]        write_count
);

  import regfile_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic              r_ack0, r_ack1, r_we, r_done, r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [7:0]        r_count;

  logic [ADDR_W-1:0] w_idx_nxt;
  logic              w_ack0_nxt, w_ack1_nxt, w_we_nxt, w_done_nxt, w_last_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic [7:0]        w_count_nxt;

  logic              w_gnt_valid;
  logic              w_gnt_idx;

  // A request whose ack is showing this cycle is masked, so a held request
  // is not granted a second time for the same write.
  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (r_state == ST_RUN),
    .i_req   ({req1, req0}),
    .i_mask  ({r_ack1, r_ack0}),
    .o_valid (w_gnt_valid),
    .o_idx   (w_gnt_idx)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_idx == LAST_IDX) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Output logic: next values of the registered write port and status.
  // Addr/data hold when idle; only enable and acks fall back to 0.
  always_comb begin
    w_idx_nxt   = r_idx;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_done_nxt  = r_done;
    w_last_nxt  = r_last;
    w_count_nxt = r_count;
    case (r_state)
      ST_INIT: begin
        w_we_nxt   = 1'b1;
        w_addr_nxt = r_idx;
        w_data_nxt = INIT_VALUE;
        w_idx_nxt  = r_idx + 1'b1;
        if (r_idx == LAST_IDX) w_done_nxt = 1'b1;
      end
      ST_RUN: begin
        if (w_gnt_valid) begin
          w_we_nxt    = 1'b1;
          w_ack0_nxt  = ~w_gnt_idx;
          w_ack1_nxt  = w_gnt_idx;
          w_addr_nxt  = w_gnt_idx ? addr1 : addr0;
          w_data_nxt  = w_gnt_idx ? data1 : data0;
          w_last_nxt  = w_gnt_idx;
          w_count_nxt = r_count + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_last  <= 1'b0;
      r_count <= '0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_last  <= w_last_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign ack0            = r_ack0;
  assign ack1            = r_ack1;
  assign rf_write_enable = r_we;
  assign rf_write_addr   = r_addr;
  assign rf_write_data   = r_data;
  assign init_done       = r_done;
  assign last_grant      = r_last;
  assign write_count     = r_count;

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Controller in front of the MIPS register file's single write port. After reset it sequences an initialisation sweep that writes a known value into every register, since the register file itself has no reset. It then shares the write port between two requesters, the ALU writeback (port 0) and the load/debug path (port 1), using round-robin arbitration with a req/ack handshake. It sits between the requesters and the register file's `write_addr`/`write_data`/`write_enable` inputs.

## Interface
Parameters:
- `DATA_W`, 4, register data width
- `ADDR_W`, 2, register address width; `NUM_REGS` = 2**`ADDR_W`
- `INIT_VALUE`, 0, value written to every register during the init sweep

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req0`, `req1`  in  1  write request from requester 0 / 1
- `addr0`, `addr1`  in  `ADDR_W`  target register for requester 0 / 1
- `data0`, `data1`  in  `DATA_W`  write data for requester 0 / 1
- `ack0`, `ack1`  out  1  one-cycle pulse, high in the cycle the granted write is presented to the register file
- `rf_write_addr`  out  `ADDR_W`  to register file `write_addr`
- `rf_write_data`  out  `DATA_W`  to register file `write_data`
- `rf_write_enable`  out  1  to register file `write_enable`
- `init_done`  out  1  high once the init sweep has completed
- `last_grant`  out  1  index of the most recently granted requester
- `write_count`  out  8  number of arbitrated writes (init writes excluded)

## Operation
- Reset values: all outputs 0; state ST_INIT; init index 0; round-robin priority set to requester 0.
- ST_INIT: cycle k (k = 0..NUM_REGS-1) drives `rf_write_enable`=1, `rf_write_addr`=k, `rf_write_data`=`INIT_VALUE`. `req*` are ignored and `ack*` stay 0. After index NUM_REGS-1 the block moves to ST_RUN and `init_done` goes to 1 and stays there until reset.
- ST_RUN: in each cycle the arbiter samples eligible requests. A requester is eligible if its `req` is high and its `ack` is not high in the current cycle; the mask prevents a held request from being granted twice.
  - Exactly one eligible: grant it.
  - Both eligible: grant the priority holder.
  - After granting requester i, priority passes to requester 1-i.
  - Grant in cycle N registers `rf_write_addr`/`rf_write_data` from the winner's `addr`/`data`. In cycle N+1 it also sets `rf_write_enable`=1, `ack<i>`=1, and `last_grant`=i, and increments `write_count`.
  - No eligible request: `rf_write_enable`=0, both acks 0. Addr/data hold their previous values.
- Handshake: a requester holds `req`/`addr`/`data` stable until it sees `ack`. It may drop `req` in the cycle after `ack`, or change `addr`/`data` then and keep `req` high to issue a new write. Changing `addr`/`data` while `req` is high and unacknowledged is illegal.
- Only one write per cycle reaches the register file, so same-address collisions between requesters cannot occur. The later grant simply overwrites.
- `write_count` wraps from 255 to 0.
- Reset asserted mid-operation clears all state immediately and asynchronously. Any in-flight write is dropped with no ack, and the init sweep reruns after `rst_n` rises. Requesters must re-issue.

## Timing
- Init sweep: NUM_REGS cycles (4 by default) beginning with the first rising edge after `rst_n` deasserts. `init_done` is high from the following cycle.
- Request-to-write latency: 1 cycle (req sampled at edge N, write presented in cycle N+1, register updated at the end of N+1).
- Throughput:
  - Two continuously requesting ports: one write per cycle, alternating 0,1,0,1.
  - A single continuously requesting port: one write every 2 cycles, because of the ack mask.
- `rf_write_*` and `ack*` are registered outputs with no combinational path from inputs.

## Structure
- Shared package `regfile_pkg`: `DATA_W`, `ADDR_W`, `NUM_REGS` constants, and the state enum {ST_INIT, ST_RUN}.
- One sub-module, `rr_arbiter2`: a 2-way round-robin grant with a priority flop and a request-mask input. It is purely a grant/priority unit; the data muxing stays in the top level.

## Test plan
- Reset then idle: release `rst_n` with no requests. Expect writes to addr 0,1,2,3 with data 0 over 4 consecutive cycles, then `init_done`=1, `rf_write_enable`=0, and `write_count`=0.
- Single write: after init, `req0`=1, `addr0`=2, `data0`=0xA. One cycle later expect `ack0`=1, `rf_write_addr`=2, `rf_write_data`=0xA, `rf_write_enable`=1, `write_count`=1. The register file then reads 0xA at addr 2.
- Contention: `req0` and `req1` both held high (addr 1/data 0x3 and addr 3/data 0x5). Expect acks alternating `ack0`, `ack1`, `ack0`, ... on consecutive cycles with `last_grant` toggling. Then swap the initial priority and check that requester 1 can win first.
- Held single request: `req1` high for 6 cycles. Expect `ack1` on cycles 1, 3, 5 only, and `write_count`=3.
- Request during init: `req0` asserted from reset release. Expect no `ack0` during the 4 init cycles; `ack0` arrives in the cycle after `init_done` rises.
- Mid-operation reset and wrap: force 255 writes, then one more, and expect `write_count`=0. Then assert `rst_n`=0 during a granted cycle: all outputs drop to 0 immediately and the init sweep repeats.
